cmp_minmax_frame: RTL and testbench

Streaming frame analyser that sits directly downstream of the 4-bit magnitude comparator (`cmp4b`). It accepts 4-bit samples over a valid/ready handshake. Two `cmp4b` instances compare each sample against a running minimum and a running maximum, and their `lt`/`gt` outputs drive the register updates. At the end of each frame the block presents min, max, their first-occurrence indices and the frame length on an output handshake.

---
 rtl/cmp_minmax_frame_if.sv | 25 ++
 rtl/cmp_minmax_frame.sv | 110 +++++++++++
 tb/tb_cmp_minmax_frame.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_minmax_frame_if.sv
// Sample input and frame-result output handshakes for cmp_minmax_frame.
// The slave modport is the analyser; the master modport is its producer/consumer.
interface cmp_minmax_frame_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_min;
  logic [3:0] out_max;
  logic [3:0] out_min_idx;
  logic [3:0] out_max_idx;
  logic [3:0] out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_len
  );
endinterface

// File: rtl/cmp_minmax_frame.sv
// Per-frame min/max analyser built around two 4-bit magnitude comparators.
// Results are latched into separate output registers so they stay frozen while the next frame accumulates.
module cmp4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

module cmp_minmax_frame #(
  parameter int FRAME_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cmp_minmax_frame_if.slave  bus
);
  localparam logic [0:0] ACC      = 1'b0;
  localparam logic [0:0] HOLD     = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic [0:0] state_reg;
  logic [3:0] cnt_reg;
  logic [3:0] min_reg, max_reg, min_idx_reg, max_idx_reg;
  logic [3:0] min_next, max_next, min_idx_next, max_idx_next;
  logic [3:0] out_min_reg, out_max_reg, out_min_idx_reg, out_max_idx_reg, out_len_reg;

  logic min_lt, min_eq, min_gt;
  logic max_lt, max_eq, max_gt;
  logic first, accept, frame_end;
  logic unused_ok;

  cmp4b u_cmp_min (.a(bus.in_data), .b(min_reg), .lt(min_lt), .eq(min_eq), .gt(min_gt));
  cmp4b u_cmp_max (.a(bus.in_data), .b(max_reg), .lt(max_lt), .eq(max_eq), .gt(max_gt));

  // Only the strict lt/gt results matter; equality keeps the earlier index.
  assign unused_ok = &{1'b0, min_eq, min_gt, max_lt, max_eq};

  assign bus.in_ready  = (state_reg == ACC);
  assign bus.out_valid = (state_reg == HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign first         = (cnt_reg == 4'd0);
  assign frame_end     = accept && (bus.in_last || (cnt_reg == LAST_IDX));

  always_comb begin
    min_next     = min_reg;
    min_idx_next = min_idx_reg;
    max_next     = max_reg;
    max_idx_next = max_idx_reg;
    if (first) begin
      min_next     = bus.in_data;
      max_next     = bus.in_data;
      min_idx_next = 4'd0;
      max_idx_next = 4'd0;
    end else begin
      if (min_lt) begin
        min_next     = bus.in_data;
        min_idx_next = cnt_reg;
      end
      if (max_gt) begin
        max_next     = bus.in_data;
        max_idx_next = cnt_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ACC;
      cnt_reg         <= 4'd0;
      min_reg         <= 4'd0;
      max_reg         <= 4'd0;
      min_idx_reg     <= 4'd0;
      max_idx_reg     <= 4'd0;
      out_min_reg     <= 4'd0;
      out_max_reg     <= 4'd0;
      out_min_idx_reg <= 4'd0;
      out_max_idx_reg <= 4'd0;
      out_len_reg     <= 4'd0;
    end else begin
      if (accept) begin
        min_reg     <= min_next;
        max_reg     <= max_next;
        min_idx_reg <= min_idx_next;
        max_idx_reg <= max_idx_next;
        cnt_reg     <= frame_end ? 4'd0 : cnt_reg + 4'd1;
      end
      if (frame_end) begin
        out_min_reg     <= min_next;
        out_max_reg     <= max_next;
        out_min_idx_reg <= min_idx_next;
        out_max_idx_reg <= max_idx_next;
        out_len_reg     <= cnt_reg + 4'd1;
        state_reg       <= HOLD;
      end else if ((state_reg == HOLD) && bus.out_ready) begin
        state_reg <= ACC;
      end
    end
  end

  assign bus.out_min     = out_min_reg;
  assign bus.out_max     = out_max_reg;
  assign bus.out_min_idx = out_min_idx_reg;
  assign bus.out_max_idx = out_max_idx_reg;
  assign bus.out_len     = out_len_reg;
endmodule

// File: tb/tb_cmp_minmax_frame.sv
// Directed bench for cmp_minmax_frame (FRAME_LEN = 8); inputs change and outputs are sampled on the falling edge.
module tb_cmp_minmax_frame;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  cmp_minmax_frame_if bus ();

  cmp_minmax_frame #(.FRAME_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input beat for one rising edge; returns on the next falling edge.
  task automatic push(input logic v, input logic [3:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle_release();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      $display("FAIL reset_handshake: got ready/valid=%b required 10", {bus.in_ready, bus.out_valid});
      fails++;
    end
    checks++;
    if ({bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !== 20'h0) begin
      $display("FAIL reset_fields: got %h required 00000",
               {bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len});
      fails++;
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] samples [8] = '{4'd5, 4'd3, 4'd9, 4'd3, 4'd0, 4'd15, 4'd7, 4'd15};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        $display("FAIL full_ready_%0d: got in_ready=%b required 1", i, bus.in_ready);
        fails++;
      end
      push(1'b1, samples[i], 1'b0);
    end
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      $display("FAIL full_hold: got valid/ready=%b required 10", {bus.out_valid, bus.in_ready});
      fails++;
    end
    checks++;
    if ({bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !== {4'd0, 4'd15, 4'd4, 4'd5, 4'd8}) begin
      $display("FAIL full_result: got min=%0d max=%0d mi=%0d xi=%0d len=%0d required 0 15 4 5 8",
               bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL full_resume: got valid/ready=%b required 01", {bus.out_valid, bus.in_ready});
      fails++;
    end
  endtask

  task automatic test_early_last();
    push(1'b1, 4'd6, 1'b0);
    push(1'b1, 4'd6, 1'b0);
    push(1'b1, 4'd2, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b1, 4'd2, 4'd6, 4'd2, 4'd0, 4'd3}) begin
      $display("FAIL early_result: got v=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 2 6 2 0 3",
               bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < 8; i++) push(1'b1, 4'd9, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b1, 4'd9, 4'd9, 4'd0, 4'd0, 4'd8}) begin
      $display("FAIL equal_result: got v=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 9 9 0 0 8",
               bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b1, 4'(i + 1), 1'b0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
          {1'b1, 1'b0, 4'd1, 4'd8, 4'd0, 4'd7, 4'd8}) begin
        $display("FAIL bp_hold_%0d: got v=%b r=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 0 1 8 0 7 8", c,
                 bus.out_valid, bus.in_ready, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
        fails++;
      end
      push(1'b1, 4'(c), 1'b1);
    end
    // Release cycle: this zero sample must be ignored because the block is still in HOLD.
    bus.out_ready = 1'b1;
    push(1'b1, 4'd0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL bp_release: got valid/ready=%b required 01", {bus.out_valid, bus.in_ready});
      fails++;
    end
    push(1'b1, 4'd12, 1'b0);
    push(1'b1, 4'd3, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b1, 4'd3, 4'd12, 4'd1, 4'd0, 4'd2}) begin
      $display("FAIL bp_next_frame: got v=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 3 12 1 0 2",
               bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
  endtask

  task automatic test_gapped();
    logic [3:0] samples [8] = '{4'd1, 4'd14, 4'd4, 4'd9, 4'd2, 4'd14, 4'd0, 4'd7};
    for (int i = 0; i < 8; i++) begin
      push(1'b1, samples[i], 1'b0);
      if (i < 7) push(1'b0, 4'd15, 1'b1);
    end
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b1, 4'd0, 4'd14, 4'd6, 4'd1, 4'd8}) begin
      $display("FAIL gapped_result: got v=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 0 14 6 1 8",
               bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
  endtask

  task automatic test_async_reset();
    logic [3:0] samples [8] = '{4'd7, 4'd2, 4'd11, 4'd2, 4'd11, 4'd4, 4'd6, 4'd3};
    push(1'b1, 4'd3, 1'b0);
    push(1'b1, 4'd8, 1'b0);
    push(1'b1, 4'd1, 1'b0);
    push(1'b1, 4'd5, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b0, 1'b1, 20'h0}) begin
      $display("FAIL arst_immediate: got v=%b r=%b fields=%h required 0 1 00000", bus.out_valid, bus.in_ready,
               {bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len});
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, samples[i], 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len} !==
        {1'b1, 4'd2, 4'd11, 4'd1, 4'd2, 4'd8}) begin
      $display("FAIL arst_after: got v=%b min=%0d max=%0d mi=%0d xi=%0d len=%0d required 1 2 11 1 2 8",
               bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_len);
      fails++;
    end
    idle_release();
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_full_frame();
    test_early_last();
    test_all_equal();
    test_backpressure();
    test_gapped();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
